// File: rtl/exc_status_unit_pkg.sv
// rtl/exc_status_unit_pkg.sv - shared constants and FSM encoding for the r30 exception status unit
package exc_pkg;

    localparam int TARGET_W    = 27;
    localparam int RSTATUS_REG = 30;

    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADD  = 2'd1;
    localparam logic [1:0] EXC_ADDI = 2'd2;
    localparam logic [1:0] EXC_SUB  = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_status_unit_if.sv
// rtl/exc_status_unit_if.sv - execute-side and pipeline-control signals of the r30 status unit
interface exc_status_if #(
    parameter int CNT_W = 8
);
    import exc_pkg::*;

    logic [1:0]          exc_code;
    logic                exc_valid;
    logic                setx_valid;
    logic [TARGET_W-1:0] setx_target;
    logic                bex_valid;
    logic [TARGET_W-1:0] bex_target;
    logic [31:0]         rstatus;
    logic                rstatus_we;
    logic [31:0]         rstatus_wdata;
    logic                branch_taken;
    logic [TARGET_W-1:0] branch_pc;
    logic                flush;
    logic [CNT_W-1:0]    ovf_count;

    modport master (
        output exc_code, exc_valid, setx_valid, setx_target, bex_valid, bex_target,
        input  rstatus, rstatus_we, rstatus_wdata, branch_taken, branch_pc, flush, ovf_count
    );

    modport slave (
        input  exc_code, exc_valid, setx_valid, setx_target, bex_valid, bex_target,
        output rstatus, rstatus_we, rstatus_wdata, branch_taken, branch_pc, flush, ovf_count
    );

endinterface

// File: rtl/exc_status_unit_flush_seq.sv
// rtl/exc_status_unit_flush_seq.sv - redirect/flush sequencer launched by a taken bex
module exc_flush_seq
    import exc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [TARGET_W-1:0] target,
    output logic                branch_taken,
    output logic [TARGET_W-1:0] branch_pc,
    output logic                flush,
    output logic                busy
);

    exc_state_t state;
    logic [2:0] cnt;

    assign busy = (state != IDLE);

    // branch_pc doubles as the captured target and is zeroed outside REDIRECT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            branch_taken <= 1'b0;
            branch_pc    <= '0;
            flush        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= REDIRECT;
                        branch_taken <= 1'b1;
                        branch_pc    <= target;
                        flush        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    branch_taken <= 1'b0;
                    branch_pc    <= '0;
                    if (FLUSH_CYCLES > 1) begin
                        state <= FLUSH;
                        cnt   <= 3'(FLUSH_CYCLES - 2);
                        flush <= 1'b1;
                    end else begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt == 3'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    branch_taken <= 1'b0;
                    branch_pc    <= '0;
                    flush        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/exc_status_unit.sv
// rtl/exc_status_unit.sv - r30 exception status register, write select, bex resolve and overflow count
module exc_status_unit
    import exc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input logic         clock,
    input logic         reset,
    exc_status_if.slave bus
);

    logic [31:0]      rstatus;
    logic [CNT_W-1:0] ovf_count;
    logic             busy;
    logic             exc_evt;
    logic             setx_evt;
    logic             we;
    logic [31:0]      wdata;
    logic [31:0]      next_rstatus;
    logic             bex_start;

    // Anything arriving while the sequencer is busy belongs to a squashed instruction
    assign exc_evt  = bus.exc_valid && (bus.exc_code != EXC_NONE) && !busy;
    assign setx_evt = bus.setx_valid && !busy && !exc_evt;
    assign we       = exc_evt || setx_evt;

    always_comb begin
        wdata = 32'd0;
        if (exc_evt) begin
            wdata = {30'd0, bus.exc_code};
        end else if (setx_evt) begin
            wdata = {{(32-TARGET_W){1'b0}}, bus.setx_target};
        end
    end

    assign next_rstatus = we ? wdata : rstatus;
    assign bex_start    = bus.bex_valid && !busy && (next_rstatus != 32'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rstatus   <= 32'd0;
            ovf_count <= '0;
        end else begin
            if (we) begin
                rstatus <= wdata;
            end
            if (exc_evt && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

    exc_flush_seq #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_seq (
        .clock        (clock),
        .reset        (reset),
        .start        (bex_start),
        .target       (bus.bex_target),
        .branch_taken (bus.branch_taken),
        .branch_pc    (bus.branch_pc),
        .flush        (bus.flush),
        .busy         (busy)
    );

    assign bus.rstatus       = rstatus;
    assign bus.rstatus_we    = we;
    assign bus.rstatus_wdata = wdata;
    assign bus.ovf_count     = ovf_count;

endmodule

// File: tb/tb_exc_status_unit.sv
// tb/tb_exc_status_unit.sv - directed self-checking bench for exc_status_unit
module tb_exc_status_unit;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    exc_status_if #(.CNT_W(8)) bus ();
    exc_status_if #(.CNT_W(2)) bus2 ();

    exc_status_unit #(.FLUSH_CYCLES(2), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exc_status_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        bus.exc_code     = 2'd0;
        bus.exc_valid    = 1'b0;
        bus.setx_valid   = 1'b0;
        bus.setx_target  = 27'd0;
        bus.bex_valid    = 1'b0;
        bus.bex_target   = 27'd0;
        bus2.exc_code    = 2'd0;
        bus2.exc_valid   = 1'b0;
        bus2.setx_valid  = 1'b0;
        bus2.setx_target = 27'd0;
        bus2.bex_valid   = 1'b0;
        bus2.bex_target  = 27'd0;
    endtask

    task automatic write_setx(input logic [26:0] t);
        @(negedge clock);
        bus.setx_valid  = 1'b1;
        bus.setx_target = t;
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.rstatus !== 32'd0) begin errors++; $display("FAIL reset_rstatus got=%h exp=%h", bus.rstatus, 32'd0); end
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch_taken got=%b exp=0", bus.branch_taken); end
        checks++; if (bus.branch_pc !== 27'd0) begin errors++; $display("FAIL reset_branch_pc got=%h exp=0", bus.branch_pc); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.rstatus_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.rstatus_we); end
        checks++; if (bus.ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf got=%0d exp=0", bus.ovf_count); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_overflow();
        @(negedge clock);
        bus.exc_valid = 1'b1;
        bus.exc_code  = 2'd3;
        #1;
        checks++; if (bus.rstatus_we !== 1'b1) begin errors++; $display("FAIL ovf_we got=%b exp=1", bus.rstatus_we); end
        checks++; if (bus.rstatus_wdata !== 32'h0000_0003) begin errors++; $display("FAIL ovf_wdata got=%h exp=00000003", bus.rstatus_wdata); end
        @(posedge clock); #1;
        checks++; if (bus.rstatus !== 32'd3) begin errors++; $display("FAIL ovf_rstatus got=%h exp=3", bus.rstatus); end
        checks++; if (bus.ovf_count !== 8'd1) begin errors++; $display("FAIL ovf_count got=%0d exp=1", bus.ovf_count); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_priority();
        @(negedge clock);
        bus.exc_valid   = 1'b1;
        bus.exc_code    = 2'd2;
        bus.setx_valid  = 1'b1;
        bus.setx_target = 27'h1234;
        #1;
        checks++; if (bus.rstatus_wdata !== 32'h0000_0002) begin errors++; $display("FAIL prio_wdata got=%h exp=00000002", bus.rstatus_wdata); end
        @(posedge clock); #1;
        checks++; if (bus.rstatus !== 32'd2) begin errors++; $display("FAIL prio_rstatus got=%h exp=2", bus.rstatus); end
        checks++; if (bus.ovf_count !== 8'd2) begin errors++; $display("FAIL prio_ovf got=%0d exp=2", bus.ovf_count); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_forwarded_bex();
        write_setx(27'd0);
        checks++; if (bus.rstatus !== 32'd0) begin errors++; $display("FAIL fwd_pre_rstatus got=%h exp=0", bus.rstatus); end
        bus.setx_valid  = 1'b1;
        bus.setx_target = 27'd5;
        bus.bex_valid   = 1'b1;
        bus.bex_target  = 27'h00ABC;
        #1;
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL fwd_early_taken got=%b exp=0", bus.branch_taken); end
        @(posedge clock); #1;
        checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL fwd_taken got=%b exp=1", bus.branch_taken); end
        checks++; if (bus.branch_pc !== 27'h00ABC) begin errors++; $display("FAIL fwd_pc got=%h exp=00abc", bus.branch_pc); end
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL fwd_flush1 got=%b exp=1", bus.flush); end
        checks++; if (bus.rstatus !== 32'd5) begin errors++; $display("FAIL fwd_rstatus got=%h exp=5", bus.rstatus); end
        @(negedge clock);
        idle_inputs();
        @(posedge clock); #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL fwd_flush2 got=%b exp=1", bus.flush); end
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL fwd_taken2 got=%b exp=0", bus.branch_taken); end
        checks++; if (bus.branch_pc !== 27'd0) begin errors++; $display("FAIL fwd_pc2 got=%h exp=0", bus.branch_pc); end
        // squashed overflow arrives during the FLUSH cycle
        @(negedge clock);
        bus.exc_valid = 1'b1;
        bus.exc_code  = 2'd1;
        #1;
        checks++; if (bus.rstatus_we !== 1'b0) begin errors++; $display("FAIL squash_we got=%b exp=0", bus.rstatus_we); end
        @(posedge clock); #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL fwd_flush3 got=%b exp=0", bus.flush); end
        checks++; if (bus.rstatus !== 32'd5) begin errors++; $display("FAIL squash_rstatus got=%h exp=5", bus.rstatus); end
        checks++; if (bus.ovf_count !== 8'd2) begin errors++; $display("FAIL squash_ovf got=%0d exp=2", bus.ovf_count); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_not_taken();
        write_setx(27'd0);
        bus.bex_valid  = 1'b1;
        bus.bex_target = 27'h123;
        @(posedge clock); #1;
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL nt_taken got=%b exp=0", bus.branch_taken); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL nt_flush got=%b exp=0", bus.flush); end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus2.exc_valid = 1'b1;
            bus2.exc_code  = 2'd1;
            @(posedge clock); #1;
            checks++;
            if (bus2.ovf_count !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
                errors++;
                $display("FAIL sat_count_%0d got=%0d exp=%0d", i, bus2.ovf_count, (i + 1 > 3) ? 3 : i + 1);
            end
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic test_reset_mid_flush();
        write_setx(27'd7);
        bus.bex_valid  = 1'b1;
        bus.bex_target = 27'h55;
        @(posedge clock); #1;
        checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL rmf_taken got=%b exp=1", bus.branch_taken); end
        @(negedge clock);
        idle_inputs();
        @(posedge clock); #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL rmf_flush_pre got=%b exp=1", bus.flush); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rmf_flush got=%b exp=0", bus.flush); end
        checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("FAIL rmf_taken0 got=%b exp=0", bus.branch_taken); end
        checks++; if (bus.rstatus !== 32'd0) begin errors++; $display("FAIL rmf_rstatus got=%h exp=0", bus.rstatus); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rmf_post_flush_%0d got=%b exp=0", i, bus.flush); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_overflow();
        test_priority();
        test_forwarded_bex();
        test_not_taken();
        test_saturation();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_status_unit.md
# exc_status_unit

Owns the processor's exception status register (`$rstatus`, r30) from the consumer side. It captures overflow exception codes from execute and `setx` targets, mirrors the value to the register file write port, and resolves `bex`. On a taken `bex` it sequences a pipeline redirect and flush. It sits beside the execute stage, between the overflow/opcode encoder and the PC-select and flush logic.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is asserted per taken `bex`. Legal range is 1–7.
- `CNT_W`, default 8: width of the saturating overflow counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `exc_code`  in  2  encoded exception code from execute: 0 none, 1 add, 2 addi, 3 sub. Only sampled when `exc_valid`.
- `exc_valid`  in  1  overflow occurred on add/addi/sub in execute this cycle.
- `setx_valid`  in  1  `setx` in execute this cycle.
- `setx_target`  in  27  `setx` immediate T.
- `bex_valid`  in  1  `bex` in execute this cycle.
- `bex_target`  in  27  `bex` jump target T.
- `rstatus`  out  32  current registered r30 value.
- `rstatus_we`  out  1  one-cycle pulse: register file must write `rstatus_wdata` to r30.
- `rstatus_wdata`  out  32  value to write.
- `branch_taken`  out  1  PC select: redirect to `branch_pc` this cycle.
- `branch_pc`  out  27  redirect target.
- `flush`  out  1  squash younger instructions in fetch and decode.
- `ovf_count`  out  CNT_W  number of accepted overflow events, saturating.

## Operation
- **Write selection.** When both `exc_valid` and `setx_valid` are high, overflow wins. Otherwise the write is `setx`, and with neither asserted there is no write.
  - Overflow write value: {30'b0, `exc_code`}.
  - `setx` write value: {5'b0, `setx_target`}.
  - `exc_valid` with `exc_code`=0 is treated as no event.
- **Register file mirror.** `rstatus_we` and `rstatus_wdata` are combinational from the accepted write in the same cycle. `rstatus` updates on the next edge.
- **bex evaluation.** The compare uses the forwarded next value: `next_rstatus` = write value if a write is accepted, else `rstatus`. `bex` is taken iff `next_rstatus` != 0.
- **FSM states:**
  - IDLE
    - A taken `bex` captures `bex_target` into `branch_pc_q` and moves to REDIRECT.
    - A not-taken `bex` has no effect.
  - REDIRECT: lasts exactly 1 cycle.
    - `branch_taken`=1, `branch_pc`=`branch_pc_q`, `flush`=1.
    - Goes to FLUSH if `FLUSH_CYCLES`>1, else to IDLE.
  - FLUSH
    - `flush`=1; a 3-bit counter counts down `FLUSH_CYCLES`-1 cycles, then returns to IDLE.
- **Squash window.** In REDIRECT and FLUSH, `exc_valid`, `setx_valid` and `bex_valid` belong to squashed instructions. They are ignored: no write, no `rstatus_we`, no count, no new `bex`.
- **Overflow counter.** `ovf_count` increments by 1 per accepted overflow event and holds at 2^CNT_W−1.
- **bex does not clear r30.** `rstatus` is cleared only by reset or overwritten by a later write.

## Timing
- Reset values, asynchronous: `rstatus`=0, `branch_pc_q`=0, `ovf_count`=0, state=IDLE, flush counter=0.
  - Hence `branch_taken`=0, `flush`=0, `rstatus_we`=0 and `branch_pc`=0 while reset is held.
- Latency:
  - write → `rstatus_we`: 0 cycles.
  - write → `rstatus`: 1 cycle.
  - `bex` in cycle N → `branch_taken` in cycle N+1.
  - `flush` high in cycles N+1 through N+`FLUSH_CYCLES`.
- A taken `bex` is always evaluated in IDLE, so back-to-back redirects are at least `FLUSH_CYCLES`+1 cycles apart.
- Reset mid-REDIRECT or mid-FLUSH aborts immediately: outputs drop in the same cycle, and there is no residual flush after reset is released.
- `branch_pc` is 0 whenever `branch_taken`=0.

## Structure
- Shared package `exc_pkg`:
  - `EXC_NONE`=0, `EXC_ADD`=1, `EXC_ADDI`=2, `EXC_SUB`=3.
  - `RSTATUS_REG`=30.
  - FSM state encoding `exc_state_t` {IDLE, REDIRECT, FLUSH}.
  - `TARGET_W`=27.
- One sub-module, `exc_flush_seq`: the REDIRECT/FLUSH FSM and countdown.
  - Inputs: `start` and target. Outputs: `branch_taken`, `branch_pc`, `flush`, `busy`.
- Top level holds write selection, the r30 register, forwarding compare and counter.

## Test plan
- **Overflow capture:** reset, then `exc_valid`=1, `exc_code`=3.
  - Same cycle: `rstatus_we`=1, `rstatus_wdata`=0x00000003.
  - Next cycle: `rstatus`=3, `ovf_count`=1.
- **Priority:** `exc_valid`=1, `exc_code`=2 together with `setx_valid`=1, `setx_target`=0x1234 → written value 0x00000002.
- **Forwarded bex:** `rstatus`=0; in the same cycle `setx_target`=5 and `bex_valid`=1, `bex_target`=0x00ABC.
  - Next cycle: `branch_taken`=1, `branch_pc`=0x00ABC.
  - `flush` high for 2 cycles, then IDLE.
- **Not-taken bex and squash window:**
  - `rstatus`=0, `bex` alone → no redirect.
  - During FLUSH, `exc_valid`=1 with code 1 → no `rstatus_we`, `rstatus` and `ovf_count` unchanged.
- **Counter saturation:** `CNT_W`=2, 5 overflow events → `ovf_count`=3.
- **Reset mid-flush:** assert `reset` in the first FLUSH cycle.
  - `flush`, `branch_taken` and `rstatus` go to 0 immediately.
  - After release: state IDLE and no further `flush`.
